// File: rtl/fsmc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fsmc_bus_ctrl
//  Function : FSMC slave controller. Resynchronises the MCU strobes to clk,
//             latches the multiplexed address, decodes three regions, issues
//             one-clock write strobes and sequences region-0 read handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module fsmc_bus_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter int          RD_TIMEOUT  = 16,
  parameter logic [15:0] FAULT_WORD  = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ne,
  input  logic        nadv,
  input  logic        nwe,
  input  logic        noe,
  input  logic [15:0] ad_in,
  input  logic [2:0]  a_hi,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic [2:0]  wr_stb,
  output logic [14:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_req,
  output logic [14:0] rd_addr,
  input  logic [15:0] rd_data,
  input  logic        rd_ack,
  output logic        err
);

  localparam int         c_TMO_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [1:0] c_REGION0 = 2'd0;
  localparam logic [1:0] c_REGION1 = 2'd1;
  localparam logic [1:0] c_REGION2 = 2'd2;
  localparam logic [1:0] c_UNMAP   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_REQ  = 3'd3,
    S_READ_HOLD = 3'd4
  } state_t;

  // Strobe bundle order: {ne, nadv, nwe, noe}
  logic [3:0]         r_sync [SYNC_STAGES];
  logic [3:0]         r_prev;
  logic [3:0]         w_cur;
  logic               w_ne_rise;
  logic               w_ne_low;
  logic               w_nadv_rise;
  logic               w_nwe_rise;
  logic               w_noe_fall;
  logic               w_noe_rise;
  logic [1:0]         w_dec_region;
  state_t             r_state;
  logic [1:0]         r_region;
  logic [c_TMO_W-1:0] r_tmo;

  // Synchroniser chains; reset to 1 so an idle bus produces no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= {ne, nadv, nwe, noe};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // One extra register after the synchronisers for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '1;
    else        r_prev <= w_cur;
  end

  assign w_cur       = r_sync[SYNC_STAGES-1];
  assign w_ne_rise   =  w_cur[3] & ~r_prev[3];
  assign w_ne_low    = ~w_cur[3];
  assign w_nadv_rise =  w_cur[2] & ~r_prev[2];
  assign w_nwe_rise  =  w_cur[1] & ~r_prev[1];
  assign w_noe_fall  = ~w_cur[0] &  r_prev[0];
  assign w_noe_rise  =  w_cur[0] & ~r_prev[0];

  // Region decode on ADDR[18:15] = {a_hi, ad_in[15]}.
  always_comb begin
    w_dec_region = c_UNMAP;
    case ({a_hi, ad_in[15]})
      4'b1010: w_dec_region = c_REGION0;
      4'b1110: w_dec_region = c_REGION1;
      4'b1111: w_dec_region = c_REGION2;
      default: w_dec_region = c_UNMAP;
    endcase
  end

  // Bus transaction state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_region <= c_UNMAP;
      r_tmo    <= '0;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      wr_stb   <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      err      <= 1'b0;
    end else begin
      wr_stb <= '0;
      if (w_ne_rise) begin
        // Chip-select release aborts whatever is in flight, without a strobe.
        r_state <= S_IDLE;
        rd_req  <= 1'b0;
        ad_oe   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_nadv_rise && w_ne_low) begin
              r_region <= w_dec_region;
              wr_addr  <= ad_in[14:0];
              rd_addr  <= ad_in[14:0];
              r_state  <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (w_nwe_rise) begin
              // A read edge coinciding with a write edge is dropped and flagged.
              wr_data <= ad_in;
              r_state <= S_WRITE;
              if (w_noe_fall) err <= 1'b1;
            end else if (w_noe_fall) begin
              if (r_region == c_REGION0) begin
                rd_req  <= 1'b1;
                r_tmo   <= '0;
                r_state <= S_READ_REQ;
              end else begin
                ad_out  <= FAULT_WORD;
                ad_oe   <= 1'b1;
                r_state <= S_READ_HOLD;
              end
            end else if (w_nadv_rise) begin
              r_region <= w_dec_region;
              wr_addr  <= ad_in[14:0];
              rd_addr  <= ad_in[14:0];
            end
          end
          S_WRITE: begin
            if (r_region == c_UNMAP) err    <= 1'b1;
            else                     wr_stb <= 3'b001 << r_region;
            r_state <= S_ADDR;
          end
          S_READ_REQ: begin
            if (rd_ack) begin
              ad_out  <= rd_data;
              ad_oe   <= 1'b1;
              rd_req  <= 1'b0;
              r_state <= S_READ_HOLD;
            end else if (r_tmo == c_TMO_W'(RD_TIMEOUT - 1)) begin
              ad_out  <= FAULT_WORD;
              ad_oe   <= 1'b1;
              rd_req  <= 1'b0;
              err     <= 1'b1;
              r_state <= S_READ_HOLD;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_READ_HOLD: begin
            if (w_noe_rise) begin
              ad_oe   <= 1'b0;
              r_state <= S_ADDR;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsmc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsmc_bus_ctrl
//  Function : Directed bench for fsmc_bus_ctrl; expected write strobes and
//             read words are queued by the stimulus and consumed by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsmc_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ne, nadv, nwe, noe;
  logic [15:0] ad_in;
  logic [2:0]  a_hi;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic [2:0]  wr_stb;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic        r_prev_oe;
  logic [15:0] r_prev_out;

  fsmc_bus_ctrl #(
    .SYNC_STAGES (2),
    .RD_TIMEOUT  (16),
    .FAULT_WORD  (16'hDEAD)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ne      (ne),
    .nadv    (nadv),
    .nwe     (nwe),
    .noe     (noe),
    .ad_in   (ad_in),
    .a_hi    (a_hi),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_ack  (rd_ack),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: consumes expected strobes / read words as the DUT presents them.
  always @(negedge clk) begin
    if (wr_stb != 3'b000) begin
      if (exp_wr.size() == 0) chk("unexpected_wr_stb", {wr_stb, wr_addr, wr_data}, 34'h0);
      else                    chk("wr_event", {wr_stb, wr_addr, wr_data}, exp_wr.pop_front());
    end
    if (ad_oe && !r_prev_oe) begin
      if (exp_rd.size() == 0) chk("unexpected_ad_oe", {18'h0, ad_out}, 34'h0);
      else                    chk("rd_word", {18'h0, ad_out}, {18'h0, exp_rd.pop_front()});
    end
    if (ad_oe && r_prev_oe) chk("ad_out_stable", {18'h0, ad_out}, {18'h0, r_prev_out});
    r_prev_oe  = ad_oe;
    r_prev_out = ad_out;
  end

  task automatic bus_addr(input logic [18:0] a);
    ne    = 1'b0;
    a_hi  = a[18:16];
    ad_in = a[15:0];
    repeat (2) @(negedge clk);
    nadv = 1'b0;
    repeat (4) @(negedge clk);
    nadv = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] d, input logic [2:0] stb, input logic [14:0] a);
    if (stb != 3'b000) exp_wr.push_back({stb, a, d});
    ad_in = d;
    nwe   = 1'b0;
    repeat (4) @(negedge clk);
    nwe = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_end();
    ne = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Read with optional acknowledge on the ack_at-th cycle of rd_req.
  task automatic bus_read(input logic [15:0] exp_out, input int ack_at,
                          input logic [15:0] data, input int exp_req);
    int seen = 0;
    bit got  = 1'b0;
    exp_rd.push_back(exp_out);
    noe = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (rd_req) begin
        seen++;
        if (ack_at > 0 && seen == ack_at) begin
          rd_ack  = 1'b1;
          rd_data = data;
        end
      end
      got = ad_oe;
    end
    rd_ack = 1'b0;
    chk("rd_oe_seen", {33'h0, got}, 34'h1);
    chk("rd_req_cycles", 34'(seen), 34'(exp_req));
    repeat (2) @(negedge clk);
    noe = 1'b1;
    repeat (2) @(negedge clk);
    chk("ad_oe_hold", {33'h0, ad_oe}, 34'h1);
    @(negedge clk);
    chk("ad_oe_drop", {33'h0, ad_oe}, 34'h0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit seen_req;
    rst_n   = 1'b0;
    ne      = 1'b1;
    nadv    = 1'b1;
    nwe     = 1'b1;
    noe     = 1'b1;
    ad_in   = 16'h0;
    a_hi    = 3'h0;
    rd_data = 16'h0;
    rd_ack  = 1'b0;
    r_prev_oe  = 1'b0;
    r_prev_out = 16'h0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ad_out", {18'h0, ad_out}, 34'h0);
    chk("rst_oe_req_err", {31'h0, ad_oe, rd_req, err}, 34'h0);
    chk("rst_wr", {wr_stb, wr_addr, wr_data}, 34'h0);
    chk("rst_rd_addr", {19'h0, rd_addr}, 34'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Region-1 single write
    bus_addr(19'h70012);
    bus_write(16'h1234, 3'b010, 15'h0012);
    chk("wr1_err", {33'h0, err}, 34'h0);
    bus_end();

    // Region-0 read, acknowledged on the third request cycle
    bus_addr(19'h50007);
    chk("rd0_addr", {19'h0, rd_addr}, {19'h0, 15'h0007});
    bus_read(16'hBEEF, 3, 16'hBEEF, 3);
    chk("rd0_err", {33'h0, err}, 34'h0);
    bus_end();

    // Region-2 burst: three writes under one address phase
    bus_addr(19'h78000);
    bus_write(16'h0001, 3'b100, 15'h0000);
    bus_write(16'h0002, 3'b100, 15'h0000);
    bus_write(16'h0003, 3'b100, 15'h0000);
    bus_end();

    // Read from write-only region 2: fault word, no request
    bus_addr(19'h78010);
    bus_read(16'hDEAD, 0, 16'h0, 0);
    bus_end();

    // Region-0 read that is never acknowledged
    bus_addr(19'h50007);
    bus_read(16'hDEAD, 0, 16'h0, 16);
    chk("tmo_err", {33'h0, err}, 34'h1);
    chk("tmo_rd_req", {33'h0, rd_req}, 34'h0);
    bus_end();

    // Reset clears the sticky fault
    #2 rst_n = 1'b0;
    #1 chk("rst_err_clear", {33'h0, err}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Unmapped write: no strobe, fault flagged
    bus_addr(19'h10000);
    bus_write(16'h5555, 3'b000, 15'h0000);
    chk("unmap_err", {33'h0, err}, 34'h1);
    bus_end();

    // Abort: NE rises while a region-0 read is requesting
    bus_addr(19'h50001);
    noe = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      @(negedge clk);
      seen_req = rd_req;
    end
    chk("abort_req_seen", {33'h0, seen_req}, 34'h1);
    ne = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_req_before", {33'h0, rd_req}, 34'h1);
    @(negedge clk);
    chk("abort_req_oe_clr", {32'h0, rd_req, ad_oe}, 34'h0);
    noe = 1'b1;
    repeat (6) @(negedge clk);

    // Reset in the middle of a write clears outputs immediately
    bus_addr(19'h70034);
    chk("mid_wr_addr", {19'h0, wr_addr}, {19'h0, 15'h0034});
    nwe = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_wr", {wr_stb, wr_addr, wr_data}, 34'h0);
    chk("mid_rst_err", {32'h0, err, rd_req}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nwe   = 1'b1;
    ne    = 1'b1;
    repeat (8) @(negedge clk);

    chk("wr_queue_empty", 34'(exp_wr.size()), 34'h0);
    chk("rd_queue_empty", 34'(exp_rd.size()), 34'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
